lfsr_checker: RTL and testbench

Receive-side companion to the 24-bit noise LFSR. It consumes the signed 16-bit samples the generator emits (state bits [23:8], taps 23/22/20/19, left-shifting) and rebuilds the generator's bit history from the stream. Once it has enough history it locks, predicts every following sample, and counts mismatches. It sits on any noise tap feeding the excitation path and serves as an in-system integrity monitor and bench scoreboard.

---
 rtl/lfsr_checker_if.sv | 20 ++
 rtl/lfsr_checker.sv | 104 ++++++++++
 tb/tb_lfsr_checker.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - sample stream and status bundle between noise tap and lfsr_checker
interface lfsr_checker_if;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               clr_cnt;
  logic               locked;
  logic               err_pulse;
  logic        [15:0] err_count;
  logic        [15:0] predicted;

  modport master (
    output sample_in, sample_valid, clr_cnt,
    input  locked, err_pulse, err_count, predicted
  );

  modport slave (
    input  sample_in, sample_valid, clr_cnt,
    output locked, err_pulse, err_count, predicted
  );
endinterface

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - rebuilds the 24-bit noise LFSR history from its samples,
// locks onto the sequence and counts mispredicted samples
module lfsr_checker #(
  parameter int LOSS_THRESH = 4
) (
  input  logic          clk,
  input  logic          reset,
  lfsr_checker_if.slave bus
);
  typedef enum logic [1:0] {FIRST, FILL, LOCK} state_t;

  state_t      state;
  logic [23:0] h;
  logic [15:0] prev;
  logic [3:0]  fill_cnt;
  logic [3:0]  miss_run;
  logic        locked_q;
  logic        err_pulse_q;
  logic [15:0] err_count_q;
  logic [15:0] predicted_q;

  logic        accept;
  logic        overlap_ok;
  logic        mismatch;
  logic        reload;
  logic [23:0] h_shift;
  logic [23:0] h_next;

  assign accept     = bus.sample_valid;
  assign h_shift    = {h[22:0], bus.sample_in[0]};
  assign overlap_ok = bus.sample_in[15:1] == prev[14:0];
  // predicted_q always equals {prev[14:0], next bit of h}, so LOCK compares against it directly
  assign mismatch   = bus.sample_in != predicted_q;
  assign reload     = (state == FIRST) || (state == FILL && !overlap_ok);
  assign h_next     = reload ? {8'h00, bus.sample_in} : h_shift;

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.predicted = predicted_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FIRST;
      h           <= '0;
      prev        <= '0;
      fill_cnt    <= '0;
      miss_run    <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      predicted_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (accept) begin
        prev        <= bus.sample_in;
        h           <= h_next;
        predicted_q <= {bus.sample_in[14:0], h_next[19] ^ h_next[20] ^ h_next[22] ^ h_next[23]};
        case (state)
          FIRST: begin
            fill_cnt <= '0;
            state    <= FILL;
          end
          FILL: begin
            if (!overlap_ok) begin
              fill_cnt <= '0;
            end else if (fill_cnt == 4'd7) begin
              // an all-zero history would predict zeros forever; keep filling instead
              if (h_shift == '0) begin
                fill_cnt <= '0;
              end else begin
                fill_cnt <= 4'd8;
                state    <= LOCK;
                locked_q <= 1'b1;
              end
            end else begin
              fill_cnt <= fill_cnt + 4'd1;
            end
          end
          LOCK: begin
            if (!mismatch) begin
              miss_run <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              if (miss_run == 4'(LOSS_THRESH - 1)) begin
                miss_run <= '0;
                state    <= FIRST;
                locked_q <= 1'b0;
              end else begin
                miss_run <= miss_run + 4'd1;
              end
            end
          end
          default: state <= FIRST;
        endcase
      end
      if (bus.clr_cnt) begin
        err_count_q <= '0;
      end else if (accept && state == LOCK && mismatch && err_count_q != 16'hFFFF) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard bench for lfsr_checker: seed lock, long run, errors,
// loss/relock, fill restart, async reset, saturation and clear priority
module tb_lfsr_checker;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lfsr_checker_if bus ();
  lfsr_checker_if bus2 ();

  lfsr_checker #(.LOSS_THRESH(4))  dut  (.clk(clk), .reset(reset), .bus(bus));
  lfsr_checker #(.LOSS_THRESH(15)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    logic [15:0] s;
    logic        v;
    logic        chk_pred;
    logic [15:0] pred;
    logic        locked;
    logic        pulse;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          due;
    logic        chk_pred;
    logic [15:0] pred;
    logic        locked;
    logic        pulse;
    logic [15:0] cnt;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [23:0] g;
  logic [15:0] s;
  logic [15:0] ecnt;
  logic        hit;
  vec_t        vt[12];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] lfsr_step(input logic [23:0] st);
    return {st[22:0], st[23] ^ st[22] ^ st[20] ^ st[19]};
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [15:0] si, input logic v, input logic clr, input logic chk,
                       input logic chk_pred, input logic [15:0] pred, input logic el,
                       input logic ep, input logic [15:0] ec, input string nm);
    exp_t e;
    @(negedge clk);
    bus.sample_in    = si;
    bus.sample_valid = v;
    bus.clr_cnt      = clr;
    if (chk) begin
      e = '{cyc + 1, chk_pred, pred, el, ep, ec, nm};
      sb.push_back(e);
    end
  endtask

  task automatic clean(input string nm, input logic el, input logic ep, input logic [15:0] ec,
                       input logic chk_pred);
    logic [15:0] si;
    si = g[23:8];
    g  = lfsr_step(g);
    apply(si, 1'b1, 1'b0, 1'b1, chk_pred, g[23:8], el, ep, ec, nm);
  endtask

  task automatic gap(input string nm, input logic el, input logic [15:0] ec);
    apply(16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, el, 1'b0, ec, nm);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      cmp({mon_e.nm, "/locked"}, 16'(bus.locked), 16'(mon_e.locked));
      cmp({mon_e.nm, "/err_pulse"}, 16'(bus.err_pulse), 16'(mon_e.pulse));
      cmp({mon_e.nm, "/err_count"}, bus.err_count, mon_e.cnt);
      if (mon_e.chk_pred) cmp({mon_e.nm, "/predicted"}, bus.predicted, mon_e.pred);
    end
  end

  initial begin
    bus.sample_in     = '0;
    bus.sample_valid  = 1'b0;
    bus.clr_cnt       = 1'b0;
    bus2.sample_in    = '0;
    bus2.sample_valid = 1'b0;
    bus2.clr_cnt      = 1'b0;

    // generator seeded at 0x000001: eight zero samples then 0x0001, with gaps mixed in
    for (int i = 0; i < 12; i++) vt[i] = '{16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vt[4]  = '{16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vt[9]  = '{16'h0001, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0000};
    vt[10] = '{16'hFFFF, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0000};
    vt[11] = '{16'h1234, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0000};

    #7;
    cmp("reset/locked", 16'(bus.locked), 16'd0);
    cmp("reset/err_pulse", 16'(bus.err_pulse), 16'd0);
    cmp("reset/err_count", bus.err_count, 16'd0);
    cmp("reset/predicted", bus.predicted, 16'd0);
    #5 reset = 1'b1;

    for (int i = 0; i < 12; i++)
      apply(vt[i].s, vt[i].v, 1'b0, 1'b1, vt[i].chk_pred, vt[i].pred, vt[i].locked,
            vt[i].pulse, vt[i].cnt, $sformatf("seed%0d", i));

    g = 24'h000200;
    for (int i = 0; i < 3000; i++) begin
      clean("long_run", 1'b1, 1'b0, 16'd0, 1'b1);
      if ($urandom_range(3) == 0)
        repeat ($urandom_range(3, 1)) gap("long_gap", 1'b1, 16'd0);
    end

    s = g[23:8];
    g = lfsr_step(g);
    apply(s ^ 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'd1, "single_err");
    gap("single_gap", 1'b1, 16'd1);
    // the bad bit breaks the next overlap, then flips the prediction as it passes taps 19/20/22/23
    ecnt = 16'd1;
    for (int k = 1; k <= 30; k++) begin
      hit = (k == 1) || (k == 20) || (k == 21) || (k == 23) || (k == 24);
      if (hit) ecnt = ecnt + 16'd1;
      clean($sformatf("single_tail%0d", k), 1'b1, hit, ecnt, 1'b0);
    end
    cmp("single_total_model", ecnt, 16'd6);

    s = g[23:8];
    g = lfsr_step(g);
    apply(s, 1'b1, 1'b1, 1'b1, 1'b1, g[23:8], 1'b1, 1'b0, 16'd0, "clr_clean");

    for (int i = 0; i < 4; i++)
      apply(16'h5A5A, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, (i < 3), 1'b1, 16'(i + 1),
            $sformatf("loss%0d", i));
    for (int i = 0; i < 9; i++)
      clean($sformatf("relock%0d", i), (i == 8), 1'b0, 16'd4, (i == 8));
    clean("relock_hold", 1'b1, 1'b0, 16'd4, 1'b1);

    apply(16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, "pre_reset");
    @(posedge clk);
    #1 bus.sample_valid = 1'b0;
    cmp("pre_reset/err_pulse", 16'(bus.err_pulse), 16'd1);
    cmp("pre_reset/err_count", bus.err_count, 16'd5);
    #1 reset = 1'b0;
    #1;
    cmp("async_reset/locked", 16'(bus.locked), 16'd0);
    cmp("async_reset/err_pulse", 16'(bus.err_pulse), 16'd0);
    cmp("async_reset/err_count", bus.err_count, 16'd0);
    cmp("async_reset/predicted", bus.predicted, 16'd0);
    @(negedge clk);
    #2 reset = 1'b1;

    g = 24'hC0FFEE;
    for (int i = 0; i < 5; i++) clean($sformatf("fill_pre%0d", i), 1'b0, 1'b0, 16'd0, 1'b0);
    g = 24'h5A17E3;
    clean("fill_break", 1'b0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      clean($sformatf("fill_post%0d", i), (i == 7), 1'b0, 16'd0, (i == 7));

    apply(16'h5A5A, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'd0, "clr_vs_err");
    apply(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, "idle");

    g = 24'h000001;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus2.sample_in    = g[23:8];
      bus2.sample_valid = 1'b1;
      g = lfsr_step(g);
    end
    @(negedge clk);
    bus2.sample_valid = 1'b0;
    cmp("sat/locked", 16'(bus2.locked), 16'd1);
    force dut2.err_count_q = 16'hFFFC;
    #1 release dut2.err_count_q;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus2.sample_in    = 16'h5A5A;
      bus2.sample_valid = 1'b1;
      @(posedge clk);
      #1;
      cmp($sformatf("sat%0d/err_count", i), bus2.err_count, (i < 3) ? 16'(16'hFFFD + i) : 16'hFFFF);
      cmp($sformatf("sat%0d/locked", i), 16'(bus2.locked), 16'd1);
    end
    @(negedge clk);
    bus2.sample_valid = 1'b0;
    bus2.clr_cnt      = 1'b1;
    @(posedge clk);
    #1;
    bus2.clr_cnt = 1'b0;
    cmp("sat/clr", bus2.err_count, 16'd0);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
